// File: rtl/reg_wr_arbiter.sv
// Two-port register-file write arbiter: round-robin grant between ALU and
// load writeback, one registered write per WR cycle, register 0 writes dropped.
module reg_wr_arbiter #(
  parameter int unsigned n = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [4:0]       Rw0,
  input  logic [4:0]       Rw1,
  input  logic [n-1:0]     Dat0,
  input  logic [n-1:0]     Dat1,
  output logic             Ack0,
  output logic             Ack1,
  output logic [4:0]       Rw,
  output logic [n-1:0]     busV,
  output logic             RegWr,
  output logic             Busy,
  output logic [7:0]       WrCnt
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            regwr_q, regwr_d;
  logic [AW-1:0]   rw_q, rw_d;
  logic [n-1:0]    busv_q, busv_d;
  logic [CW-1:0]   wrcnt_q, wrcnt_d;

  logic            elig0, elig1, any_elig, win1;

  // State and output registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busv_q  <= '0;
      wrcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busv_q  <= busv_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    regwr_d  = 1'b0;
    rw_d     = rw_q;
    busv_d   = busv_q;
    wrcnt_d  = wrcnt_q;

    // A port acked this cycle is still holding its old request; exclude it
    elig0    = Req0 & ~ack0_q;
    elig1    = Req1 & ~ack1_q;
    any_elig = elig0 | elig1;
    win1     = elig1 & (~elig0 | ptr_q);

    case (state_q)
      ST_IDLE: state_d = any_elig ? ST_WR : ST_IDLE;
      ST_WR:   state_d = any_elig ? ST_WR : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (any_elig) begin
      ptr_d   = ~win1;
      ack0_d  = ~win1;
      ack1_d  = win1;
      rw_d    = win1 ? Rw1 : Rw0;
      busv_d  = win1 ? Dat1 : Dat0;
      regwr_d = (rw_d != AW'(0));
      wrcnt_d = wrcnt_q + CW'(regwr_d);
    end
  end

  assign Ack0  = ack0_q;
  assign Ack1  = ack1_q;
  assign Rw    = rw_q;
  assign busV  = busv_q;
  assign RegWr = regwr_q;
  assign WrCnt = wrcnt_q;
  assign Busy  = (state_q == ST_WR);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter.
module tb_reg_wr_arbiter;

  localparam int unsigned N = 32;

  logic          Clock;
  logic          Resetn;
  logic          Req0, Req1;
  logic [4:0]    Rw0, Rw1;
  logic [N-1:0]  Dat0, Dat1;
  logic          Ack0, Ack1;
  logic [4:0]    Rw;
  logic [N-1:0]  busV;
  logic          RegWr;
  logic          Busy;
  logic [7:0]    WrCnt;

  int n_tests = 0;
  int n_fail  = 0;

  reg_wr_arbiter #(.n(N)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Req0  (Req0),
    .Req1  (Req1),
    .Rw0   (Rw0),
    .Rw1   (Rw1),
    .Dat0  (Dat0),
    .Dat1  (Dat1),
    .Ack0  (Ack0),
    .Ack1  (Ack1),
    .Rw    (Rw),
    .busV  (busV),
    .RegWr (RegWr),
    .Busy  (Busy),
    .WrCnt (WrCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Assert reset, then release it mid-cycle so the next edge is the first arbitration
  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #3;
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0;
    Rw0 = '0; Rw1 = '0;
    Dat0 = '0; Dat1 = '0;
    #2;
    check("rst_regwr", 32'(RegWr), 32'd0);
    check("rst_ack",   32'({Ack0, Ack1}), 32'd0);
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_rw",    32'(Rw), 32'd0);
    check("rst_busv",  busV, 32'd0);
    check("rst_cnt",   32'(WrCnt), 32'd0);
    do_reset();

    // Lone request
    Req0 = 1'b1; Rw0 = 5'd5; Dat0 = 32'h11;
    tick();
    check("lone_ack",   32'({Ack0, Ack1}), 32'b10);
    check("lone_rw",    32'(Rw), 32'd5);
    check("lone_busv",  busV, 32'h11);
    check("lone_regwr", 32'(RegWr), 32'd1);
    check("lone_busy",  32'(Busy), 32'd1);
    check("lone_cnt",   32'(WrCnt), 32'd1);
    Req0 = 1'b0;
    tick();
    check("idle_ack",   32'({Ack0, Ack1}), 32'b00);
    check("idle_regwr", 32'(RegWr), 32'd0);
    check("idle_busy",  32'(Busy), 32'd0);
    check("idle_rw",    32'(Rw), 32'd5);
    check("idle_busv",  busV, 32'h11);

    // Contention from reset: requests held through reset release
    Resetn = 1'b0;
    Req0 = 1'b1; Rw0 = 5'd1; Dat0 = 32'hAA;
    Req1 = 1'b1; Rw1 = 5'd2; Dat1 = 32'hBB;
    #1;
    check("cont_rst_cnt", 32'(WrCnt), 32'd0);
    do_reset();
    tick();
    check("cont0_ack",   32'({Ack0, Ack1}), 32'b10);
    check("cont0_rw",    32'(Rw), 32'd1);
    check("cont0_busv",  busV, 32'hAA);
    check("cont0_regwr", 32'(RegWr), 32'd1);
    Req0 = 1'b0;
    tick();
    check("cont1_ack",   32'({Ack0, Ack1}), 32'b01);
    check("cont1_rw",    32'(Rw), 32'd2);
    check("cont1_busv",  busV, 32'hBB);
    check("cont1_regwr", 32'(RegWr), 32'd1);
    check("cont1_cnt",   32'(WrCnt), 32'd2);
    Req1 = 1'b0;
    tick();
    check("cont_idle_busy", 32'(Busy), 32'd0);

    // Register zero write: acked but dropped
    Req1 = 1'b1; Rw1 = 5'd0; Dat1 = 32'hFF;
    tick();
    check("r0_ack",   32'({Ack0, Ack1}), 32'b01);
    check("r0_regwr", 32'(RegWr), 32'd0);
    check("r0_busy",  32'(Busy), 32'd1);
    check("r0_cnt",   32'(WrCnt), 32'd2);
    Req1 = 1'b0;
    tick();
    check("r0_cnt_after", 32'(WrCnt), 32'd2);

    // Starvation and counter wrap: both held for 300 grants
    do_reset();
    Req0 = 1'b1; Rw0 = 5'd3; Dat0 = 32'h3333;
    Req1 = 1'b1; Rw1 = 5'd4; Dat1 = 32'h4444;
    for (int i = 0; i < 300; i++) begin
      tick();
      check($sformatf("alt_ack[%0d]", i), 32'({Ack0, Ack1}), (i % 2 == 0) ? 32'b10 : 32'b01);
    end
    check("wrap_cnt",   32'(WrCnt), 32'd44);
    check("wrap_regwr", 32'(RegWr), 32'd1);
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    check("wrap_idle", 32'(Busy), 32'd0);

    // Lone port streaming: new data after each ack
    Req0 = 1'b1; Rw0 = 5'd9; Dat0 = 32'h100;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("stream_busy[%0d]", i), 32'(Busy), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("stream_ack[%0d]", i), 32'(Ack0), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("stream_busv[%0d]", i), busV, 32'h100 + 32'(i / 2));
      if (Ack0) Dat0 = Dat0 + 32'd1;
    end
    check("stream_cnt", 32'(WrCnt), 32'd47);
    Req0 = 1'b0;
    tick();

    // Reset mid-WR aborts the write without a clock edge
    Req0 = 1'b1; Rw0 = 5'd7; Dat0 = 32'h77;
    tick();
    check("mid_regwr_pre", 32'(RegWr), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check("mid_regwr", 32'(RegWr), 32'd0);
    check("mid_ack",   32'({Ack0, Ack1}), 32'd0);
    check("mid_busy",  32'(Busy), 32'd0);
    check("mid_cnt",   32'(WrCnt), 32'd0);
    Req0 = 1'b0;
    do_reset();
    tick();
    check("mid_no_regrant", 32'({Ack0, Ack1}), 32'd0);
    check("mid_no_busy",    32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 The block SHALL have parameter n, default 32, meaning the write-data width, matching the register file data bus.
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Resetn, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have ports Req0/Req1, input, 1 bit each: write requests from the ALU writeback (0) and memory-load writeback (1).
REQ-005 The block SHALL have ports Rw0/Rw1, input, 5 bits each: the destination register address for each requester.
REQ-006 The block SHALL have ports Dat0/Dat1, input, n bits each: the write data for each requester.
REQ-007 The block SHALL have ports Ack0/Ack1, output, 1 bit each: a one-cycle grant/done pulse per requester.
REQ-008 The block SHALL have port Rw, output, 5 bits: the write address to the register file.
REQ-009 The block SHALL have port busV, output, n bits: the write data to the register file.
REQ-010 The block SHALL have port RegWr, output, 1 bit: the register-file write enable.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while the FSM is in WR.
REQ-012 The block SHALL have port WrCnt, output, 8 bits: the count of committed register writes.

Function
REQ-013 Handshake: a requester SHALL hold Req, Rw and Dat stable until it samples its Ack high, then deassert Req or present a new request on the next cycle.
REQ-014 The FSM SHALL have two states, IDLE and WR, both registered, with all outputs registered.
REQ-015 At each rising edge, the eligible set SHALL be {i : Reqi=1} minus the port acked in the current cycle.
REQ-016 IDLE SHALL go to WR when the eligible set is non-empty, and stay IDLE otherwise.
REQ-017 WR SHALL stay in WR when the eligible set is non-empty, and go to IDLE otherwise.
REQ-018 Arbitration SHALL be round-robin via a 1-bit pointer.
- If both ports are eligible, the pointed port wins and the pointer moves to the other port.
- If one port is eligible, it wins and the pointer moves to the other port.
REQ-019 On entering or staying in WR, the block SHALL register Rw ← RwW and busV ← DatW for winner W, and pulse AckW=1 for exactly that WR cycle; the other Ack SHALL be 0.
REQ-020 RegWr SHALL be 1 in a WR cycle only if the granted Rw≠0; writes to register 0 SHALL be acked but dropped (RegWr=0).
REQ-021 RegWr/Rw/busV SHALL be stable for the whole WR cycle so the register file samples them at the falling edge mid-cycle.
REQ-022 WrCnt SHALL increment by 1 for each cycle with RegWr=1, wrapping 255→0; dropped register-0 writes SHALL not count.
REQ-023 Back-to-back throughput: alternating ports SHALL be served with one write per cycle; a lone port held high SHALL be served at most every second cycle (WR, IDLE, WR ...).
REQ-024 Simultaneous requests to the same Rw SHALL be serialized in round-robin order, the later grant overwriting the earlier.
REQ-025 In IDLE, RegWr=0 and Ack0=Ack1=0; Rw and busV SHALL hold their last values.

Reset
REQ-026 When Resetn=0, the block SHALL immediately set state=IDLE, RegWr=0, Ack0=Ack1=0, Busy=0, Rw=0, busV=0, WrCnt=0 and pointer=port 0.
REQ-027 Reset asserted during WR SHALL abort the write: RegWr drops asynchronously, and the grant is not repeated after release unless Req is still held.
REQ-028 The first arbitration SHALL occur at the first rising edge with Resetn=1.

Verification
REQ-029 Reset check: apply Resetn=0 mid-WR → RegWr, Ack0, Ack1, Busy and WrCnt read 0 without waiting for a clock edge.
REQ-030 Lone request: Req0=1, Rw0=5, Dat0=0x11 for one grant → the next cycle shows Rw=5, busV=0x11, RegWr=1, Ack0=1, and WrCnt goes 0→1.
REQ-031 Contention: Req0=Req1=1 from reset, Rw0=1/Dat0=0xAA, Rw1=2/Dat1=0xBB → port 0 is granted first, port 1 in the next cycle, two consecutive RegWr cycles, WrCnt=2.
REQ-032 Register zero: Req1=1, Rw1=0, Dat1=0xFF → Ack1=1, RegWr=0, WrCnt unchanged.
REQ-033 Starvation and wrap: hold Req0 and Req1 high continuously for 300 grants → Ack0 and Ack1 strictly alternate, and WrCnt wraps to 300 mod 256 = 44.
REQ-034 Lone port streaming: hold Req0=1 with changing data → grants occur every second cycle and Busy toggles 1,0,1,0.
